// File: rtl/uart_reg_control_pkg.sv
// uart_reg_control_pkg: packet beat type, controller states and constants for the register-access controller.
// Shared by uart_reg_control and uart_ctrl_regfile.
package uart_reg_control_pkg;

    typedef struct packed {
        logic [7:0] Destination;
        logic [7:0] Source;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       Valid;
    } UART_PACKET;

    typedef enum logic [1:0] {IDLE, COLLECT, REPLY} CTRL_STATE;

    localparam logic [7:0] CTRL_LEN_READ = 8'd1;

    function automatic UART_PACKET mk_reply(input logic [7:0] dst, input logic [7:0] src, input logic [7:0] data);
        mk_reply = '{Destination: dst, Source: src, Length: CTRL_LEN_READ, Data: data, SoP: 1'b1, Valid: 1'b1};
    endfunction

endpackage

// File: rtl/uart_ctrl_regfile.sv
// uart_ctrl_regfile: NUM_REGS x 8-bit register bank with one write port, a combinational read port
// and the whole bank flattened onto o_regs (reg k on bits [8k+7:8k]).
module uart_ctrl_regfile
    import uart_reg_control_pkg::*;
#(
    parameter  int NUM_REGS = 16,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [7:0]            i_wr_data,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [7:0]            o_rd_data,
    output logic [NUM_REGS*8-1:0] o_regs
);

    logic [7:0] r_mem [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign o_regs[8*k +: 8] = r_mem[k];
    end

endmodule

// File: rtl/uart_reg_control.sv
// uart_reg_control: decodes read/write packets addressed to NODE_ADDR, updates the register bank and
// returns a one-byte reply beat. Optional error counter enabled by UART_CTRL_ERR_COUNT_EN.
module uart_reg_control
    import uart_reg_control_pkg::*;
#(
    parameter logic [7:0] NODE_ADDR = 8'h7A,
    parameter int         NUM_REGS  = 16
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    input  UART_PACKET            ipRxStream,
    output UART_PACKET            opTxStream,
    input  logic                  ipTxReady,
    output logic [NUM_REGS*8-1:0] opRegs
`ifdef UART_CTRL_ERR_COUNT_EN
    ,
    output logic [7:0]            opErrCount
`endif
);

    localparam int AW = $clog2(NUM_REGS);

    CTRL_STATE     r_state, w_state_nx;
    logic [AW-1:0] r_addr, w_addr_nx;
    logic [7:0]    r_src, w_src_nx;
    logic [7:0]    r_len, w_len_nx;
    logic [7:0]    r_cnt, w_cnt_nx;
    UART_PACKET    r_tx, w_tx_nx;
    logic [7:0]    w_rd_data;
    logic          w_wr_en;
    logic          w_sop;
    logic          w_ours;
    logic          w_hdr_ok;

    assign w_sop    = ipRxStream.Valid && ipRxStream.SoP;
    assign w_ours   = ipRxStream.Destination == NODE_ADDR;
    assign w_hdr_ok = w_ours && ipRxStream.Length != 8'd0 && ipRxStream.Data < 8'(NUM_REGS);

    uart_ctrl_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .i_clk     (ipClk),
        .i_rst_n   (ipReset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_addr),
        .i_wr_data (ipRxStream.Data),
        .i_rd_addr (ipRxStream.Data[AW-1:0]),
        .o_rd_data (w_rd_data),
        .o_regs    (opRegs)
    );

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_src   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_tx    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_addr  <= w_addr_nx;
            r_src   <= w_src_nx;
            r_len   <= w_len_nx;
            r_cnt   <= w_cnt_nx;
            r_tx    <= w_tx_nx;
        end
    end

    // A SoP seen outside REPLY is always decoded, so it overrides any burst in progress.
    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_src_nx   = r_src;
        w_len_nx   = r_len;
        w_cnt_nx   = r_cnt;
        w_tx_nx    = r_tx;
        w_wr_en    = 1'b0;
        if (r_state == REPLY) begin
            if (ipTxReady) begin
                w_state_nx = IDLE;
                w_tx_nx    = '0;
            end
        end else begin
            if (r_state == COLLECT && ipRxStream.Valid && !ipRxStream.SoP) begin
                w_wr_en   = 1'b1;
                w_addr_nx = r_addr + 1'b1;
                w_cnt_nx  = r_cnt + 8'd1;
                if (w_cnt_nx == r_len) begin
                    w_state_nx = REPLY;
                    w_tx_nx    = mk_reply(r_src, NODE_ADDR, r_len - 8'd1);
                end
            end
            if (w_sop) begin
                w_state_nx = IDLE;
                if (w_hdr_ok) begin
                    w_addr_nx  = ipRxStream.Data[AW-1:0];
                    w_src_nx   = ipRxStream.Source;
                    w_len_nx   = ipRxStream.Length;
                    w_cnt_nx   = 8'd1;
                    w_state_nx = (ipRxStream.Length == CTRL_LEN_READ) ? REPLY : COLLECT;
                    if (ipRxStream.Length == CTRL_LEN_READ)
                        w_tx_nx = mk_reply(ipRxStream.Source, NODE_ADDR, w_rd_data);
                end
            end
        end
    end

    assign opTxStream = r_tx;

`ifdef UART_CTRL_ERR_COUNT_EN
    logic [7:0] r_err;
    logic [1:0] w_err_inc;
    logic [8:0] w_err_sum;

    // An aborting SoP that is itself undecodable costs two errors in the same cycle.
    assign w_err_inc = {1'b0, r_state == COLLECT && w_sop}
                     + {1'b0, r_state != REPLY && w_sop && w_ours && !w_hdr_ok}
                     + {1'b0, r_state == REPLY && w_sop};
    assign w_err_sum = {1'b0, r_err} + {7'd0, w_err_inc};

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) r_err <= '0;
        else          r_err <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
    end

    assign opErrCount = r_err;
`endif

endmodule

// File: tb/tb_uart_reg_control.sv
// tb_uart_reg_control: directed vector table, hand-written abort/reset sequences and random packets
// checked against a packet-level register model.
module tb_uart_reg_control;
    import uart_reg_control_pkg::*;

    localparam logic [7:0] NODE = 8'h7A;
    localparam int         NR   = 16;

    typedef struct {
        logic [7:0] dst, src, len;
        logic [7:0] b0, b1, b2, b3;
        int         nb;
        bit         rep;
        logic [7:0] rdata;
        int         dly;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_ready = 1'b0;
    UART_PACKET rx, tx;
    logic [NR*8-1:0] regs;
`ifdef UART_CTRL_ERR_COUNT_EN
    logic [7:0] err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] pb [16];
    logic [7:0] mreg [NR];
    int m_err = 0;
    bit m_rep;
    logic [7:0] m_data, m_dst;
    vec_t vt [6];

    always #5 clk = ~clk;

    uart_reg_control #(.NODE_ADDR(NODE), .NUM_REGS(NR)) dut (
        .ipClk      (clk),
        .ipReset    (rst_n),
        .ipRxStream (rx),
        .opTxStream (tx),
        .ipTxReady  (tx_ready),
        .opRegs     (regs)
`ifdef UART_CTRL_ERR_COUNT_EN
        ,
        .opErrCount (err_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_err(input string nm);
`ifdef UART_CTRL_ERR_COUNT_EN
        chk({nm, " errcnt"}, 128'(err_cnt), 128'(m_err));
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    function automatic logic [127:0] mflat();
        logic [127:0] r = '0;
        for (int k = 0; k < NR; k++) r[8*k +: 8] = mreg[k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packet-level model: decides reply/error and applies burst writes with modulo addressing.
    task automatic ref_apply(input logic [7:0] dst, input logic [7:0] src, input logic [7:0] len);
        m_rep = 1'b0;
        if (dst != NODE) return;
        if (len == 8'd0 || pb[0] >= 8'(NR)) begin
            m_err = (m_err >= 255) ? 255 : m_err + 1;
            return;
        end
        m_rep = 1'b1;
        m_dst = src;
        if (len == 8'd1) begin
            m_data = mreg[pb[0][3:0]];
        end else begin
            for (int i = 1; i < int'(len); i++) mreg[(int'(pb[0]) + i - 1) % NR] = pb[i];
            m_data = len - 8'd1;
        end
    endtask

    task automatic send_pkt(input logic [7:0] dst, input logic [7:0] src, input logic [7:0] len, input int nb);
        for (int i = 0; i < nb; i++) begin
            rx.Valid       = 1'b1;
            rx.SoP         = (i == 0);
            rx.Destination = (i == 0) ? dst : 8'($urandom);
            rx.Source      = (i == 0) ? src : 8'($urandom);
            rx.Length      = (i == 0) ? len : 8'($urandom);
            rx.Data        = pb[i];
            tick();
        end
        rx = '0;
    endtask

    task automatic check_reply(input string nm, input bit rep, input logic [7:0] dst, input logic [7:0] data, input int dly);
        UART_PACKET e;
        if (!rep) begin
            chk({nm, " no reply"}, 128'(tx.Valid), 128'(0));
            return;
        end
        e = '{Destination: dst, Source: NODE, Length: 8'd1, Data: data, SoP: 1'b1, Valid: 1'b1};
        chk({nm, " reply"}, 128'(tx), 128'(e));
        for (int d = 0; d < dly; d++) begin
            tick();
            chk({nm, " hold"}, 128'(tx), 128'(e));
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk({nm, " consumed"}, 128'({tx.Valid, tx.SoP}), 128'(0));
    endtask

    initial begin
        rx = '0;
        for (int k = 0; k < NR; k++) mreg[k] = 8'h00;
        vt[0] = '{8'h7A, 8'h2C, 8'd4, 8'h03, 8'h11, 8'h22, 8'h33, 4, 1'b1, 8'h03, 0};
        vt[1] = '{8'h7A, 8'h15, 8'd1, 8'h04, 8'h00, 8'h00, 8'h00, 1, 1'b1, 8'h22, 5};
        vt[2] = '{8'h7A, 8'h2C, 8'd3, 8'h0F, 8'hAA, 8'hBB, 8'h00, 3, 1'b1, 8'h02, 1};
        vt[3] = '{8'h7B, 8'h2C, 8'd2, 8'h01, 8'hEE, 8'h00, 8'h00, 2, 1'b0, 8'h00, 0};
        vt[4] = '{8'h7A, 8'h2C, 8'd1, 8'h20, 8'h00, 8'h00, 8'h00, 1, 1'b0, 8'h00, 0};
        vt[5] = '{8'h7A, 8'h2C, 8'd0, 8'h02, 8'h00, 8'h00, 8'h00, 1, 1'b0, 8'h00, 0};

        repeat (3) tick();
        chk("reset tx", 128'(tx), 128'(0));
        chk("reset regs", regs, 128'(0));
        rst_n = 1'b1;
        chk_err("reset");

        for (int i = 0; i < 6; i++) begin
            pb[0] = vt[i].b0; pb[1] = vt[i].b1; pb[2] = vt[i].b2; pb[3] = vt[i].b3;
            ref_apply(vt[i].dst, vt[i].src, vt[i].len);
            send_pkt(vt[i].dst, vt[i].src, vt[i].len, vt[i].nb);
            check_reply($sformatf("vec%0d", i), vt[i].rep, vt[i].src, vt[i].rdata, vt[i].dly);
            chk($sformatf("vec%0d regs", i), regs, mflat());
            chk_err($sformatf("vec%0d", i));
        end
        chk("wrap reg15", 128'(regs[127:120]), 128'(8'hAA));
        chk("wrap reg0", 128'(regs[7:0]), 128'(8'hBB));

        pb[0] = 8'h08; pb[1] = 8'h55;
        send_pkt(NODE, 8'h2C, 8'd4, 2);
        chk("abort mid", 128'(tx.Valid), 128'(0));
        mreg[8] = 8'h55;
        m_err = (m_err >= 255) ? 255 : m_err + 1;
        pb[0] = 8'h09; pb[1] = 8'h66;
        ref_apply(NODE, 8'h2C, 8'd2);
        send_pkt(NODE, 8'h2C, 8'd2, 2);
        check_reply("abort", 1'b1, 8'h2C, 8'h01, 0);
        chk("abort regs", regs, mflat());
        chk("abort reg10", 128'(regs[87:80]), 128'(0));
        chk_err("abort");

        pb[0] = 8'h03;
        send_pkt(NODE, 8'h33, 8'd1, 1);
        chk("rst pre valid", 128'(tx.Valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("rst mid tx", 128'(tx), 128'(0));
        chk("rst mid regs", regs, 128'(0));
        for (int k = 0; k < NR; k++) mreg[k] = 8'h00;
        m_err = 0;
        tick();
        rst_n = 1'b1;
        chk_err("rst mid");

        for (int n = 0; n < 150; n++) begin
            logic [7:0] dst, src, len;
            int nb;
            repeat ($urandom_range(0, 2)) tick();
            dst = ($urandom_range(0, 3) == 0) ? 8'($urandom) : NODE;
            src = 8'($urandom);
            len = 8'($urandom_range(0, 6));
            nb  = (len == 8'd0) ? 1 : int'(len);
            pb[0] = 8'($urandom_range(0, 19));
            for (int i = 1; i < 16; i++) pb[i] = 8'($urandom);
            ref_apply(dst, src, len);
            send_pkt(dst, src, len, nb);
            check_reply($sformatf("rnd%0d", n), m_rep, m_dst, m_data, $urandom_range(0, 3));
            chk($sformatf("rnd%0d regs", n), regs, mflat());
            chk_err($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
